// File: rtl/packer.sv
// Packs packed_num_p narrow elements LSB-first into one output word with ready/valid on both sides.
// Optional PACKER_FLUSH_EN adds flush_i/count_o to emit a partially filled word.
`timescale 1ns/1ps
module packer #(
  parameter int unsigned unpacked_width_p = 2,
  parameter int unsigned packed_num_p     = 4,
  parameter int unsigned packed_width_p   = unpacked_width_p * packed_num_p
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [unpacked_width_p-1:0] unpacked_i,
  input  logic                        valid_i,
  output logic                        ready_o,
`ifdef PACKER_FLUSH_EN
  input  logic                        flush_i,
  output logic [$clog2(packed_num_p+1)-1:0] count_o,
`endif
  output logic [packed_width_p-1:0]   packed_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  localparam int unsigned CntW     = $clog2(packed_num_p);
  localparam int unsigned LaneCntW = $clog2(packed_num_p + 1);
  localparam logic [CntW-1:0] LastLane = CntW'(packed_num_p - 1);

  logic [CntW-1:0]           count_q, count_d;
  logic [packed_width_p-1:0] asm_q, asm_d;
  logic [packed_width_p-1:0] packed_q, packed_d;
  logic                      valid_q, valid_d;
  logic [packed_width_p-1:0] merged;
  logic                      out_free, last_lane, in_fire, out_fire, emit;
`ifdef PACKER_FLUSH_EN
  logic [LaneCntW-1:0]       lanes_q, lanes_d;
`endif

  // Handshake, lane merge and next-state selection
  always_comb begin
    out_free  = !valid_q || ready_i;
    last_lane = (count_q == LastLane);
`ifdef PACKER_FLUSH_EN
    ready_o   = !((last_lane || flush_i) && !out_free);
`else
    ready_o   = !(last_lane && !out_free);
`endif
    in_fire   = valid_i && ready_o;
    out_fire  = valid_q && ready_i;

    merged = asm_q;
    for (int unsigned k = 0; k < packed_num_p; k++) begin
      if (in_fire && (CntW'(k) == count_q)) begin
        merged[k*unpacked_width_p +: unpacked_width_p] = unpacked_i;
      end
    end

    emit = in_fire && last_lane;
`ifdef PACKER_FLUSH_EN
    // A flush can complete a word early, folding in this cycle's element
    emit = emit || (flush_i && out_free && ((count_q != '0) || in_fire));
`endif

    count_d  = count_q;
    asm_d    = asm_q;
    packed_d = packed_q;
    valid_d  = valid_q;
`ifdef PACKER_FLUSH_EN
    lanes_d  = lanes_q;
`endif

    if (emit) begin
      packed_d = merged;
      valid_d  = 1'b1;
      count_d  = '0;
      asm_d    = '0;
`ifdef PACKER_FLUSH_EN
      lanes_d  = LaneCntW'(count_q) + LaneCntW'(in_fire);
`endif
    end else begin
      if (out_fire) begin
        valid_d = 1'b0;
      end
      if (in_fire) begin
        asm_d   = merged;
        count_d = count_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q  <= '0;
      asm_q    <= '0;
      packed_q <= '0;
      valid_q  <= 1'b0;
`ifdef PACKER_FLUSH_EN
      lanes_q  <= '0;
`endif
    end else begin
      count_q  <= count_d;
      asm_q    <= asm_d;
      packed_q <= packed_d;
      valid_q  <= valid_d;
`ifdef PACKER_FLUSH_EN
      lanes_q  <= lanes_d;
`endif
    end
  end

  assign packed_o = packed_q;
  assign valid_o  = valid_q;
`ifdef PACKER_FLUSH_EN
  assign count_o  = lanes_q;
`endif

endmodule

// File: tb/tb_packer.sv
// Self-checking bench for packer: directed scenarios plus randomized scoreboard runs on W2/N4 and W3/N3.
`timescale 1ns/1ps
module tb_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] da;
  logic       va, ra, ready_a, valid_a;
  logic [7:0] packed_a;
  logic [2:0] db;
  logic       vb, rb, ready_b, valid_b;
  logic [8:0] packed_b;
`ifdef PACKER_FLUSH_EN
  logic       fl_a;
  logic [2:0] cnt_a;
  logic [1:0] cnt_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  packer #(.unpacked_width_p(2), .packed_num_p(4)) dut_a (
    .clk_i(clk), .reset_ni(rst_n), .unpacked_i(da), .valid_i(va), .ready_o(ready_a),
`ifdef PACKER_FLUSH_EN
    .flush_i(fl_a), .count_o(cnt_a),
`endif
    .packed_o(packed_a), .valid_o(valid_a), .ready_i(ra));

  packer #(.unpacked_width_p(3), .packed_num_p(3)) dut_b (
    .clk_i(clk), .reset_ni(rst_n), .unpacked_i(db), .valid_i(vb), .ready_o(ready_b),
`ifdef PACKER_FLUSH_EN
    .flush_i(1'b0), .count_o(cnt_b),
`endif
    .packed_o(packed_b), .valid_o(valid_b), .ready_i(rb));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] word4(input int e0, input int e1, input int e2, input int e3);
    return 8'((e0 & 3) + ((e1 & 3) * 4) + ((e2 & 3) * 16) + ((e3 & 3) * 64));
  endfunction

  task automatic pulse_reset();
    va = 1'b0; vb = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; va = 1'b0; vb = 1'b0; ra = 1'b1; rb = 1'b1; da = '0; db = '0;
`ifdef PACKER_FLUSH_EN
    fl_a = 1'b0;
`endif
    #2;
    checks++;
    if (valid_a !== 1'b0 || packed_a !== 8'h00) begin
      errors++; $display("FAIL reset_out: got valid=%b packed=%h want 0/00", valid_a, packed_a);
    end
    #1 rst_n = 1'b1;
    step();
    checks++;
    if (ready_a !== 1'b1 || valid_a !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got ready=%b valid=%b want 1/0", ready_a, valid_a);
    end
`ifdef PACKER_FLUSH_EN
    checks++;
    if (cnt_a !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", cnt_a);
    end
`endif
  endtask

  task automatic test_basic();
    int seq[4] = '{1, 2, 3, 0};
    ra = 1'b1;
    for (int i = 0; i < 4; i++) begin
      va = 1'b1; da = 2'(seq[i]);
      #1;
      checks++;
      if (valid_a !== 1'b0 || ready_a !== 1'b1) begin
        errors++; $display("FAIL basic_fill%0d: got valid=%b ready=%b want 0/1", i, valid_a, ready_a);
      end
      step();
    end
    va = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || packed_a !== 8'h39) begin
      errors++; $display("FAIL basic_word: got valid=%b packed=%h want 1/39", valid_a, packed_a);
    end
`ifdef PACKER_FLUSH_EN
    checks++;
    if (cnt_a !== 3'd4) begin
      errors++; $display("FAIL basic_count: got %0d want 4", cnt_a);
    end
`endif
    step();
    checks++;
    if (valid_a !== 1'b0) begin
      errors++; $display("FAIL basic_one_cycle: got valid=%b want 0", valid_a);
    end
  endtask

  task automatic test_back_to_back();
    int e[8];
    logic [7:0] w1, w2;
    for (int i = 0; i < 8; i++) e[i] = int'($urandom_range(0, 3));
    w1 = word4(e[0], e[1], e[2], e[3]);
    w2 = word4(e[4], e[5], e[6], e[7]);
    ra = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (valid_a !== ((c == 4) || (c == 8))) begin
        errors++; $display("FAIL b2b_valid c%0d: got %b", c, valid_a);
      end
      if (c == 4 || c == 8) begin
        checks++;
        if (packed_a !== (c == 4 ? w1 : w2)) begin
          errors++; $display("FAIL b2b_word c%0d: got %h want %h", c, packed_a, (c == 4 ? w1 : w2));
        end
      end
      va = (c < 8);
      da = 2'(e[c % 8]);
      #1;
      if (c < 8) begin
        checks++;
        if (ready_a !== 1'b1) begin
          errors++; $display("FAIL b2b_ready c%0d: got %b want 1", c, ready_a);
        end
      end
      step();
    end
    va = 1'b0;
  endtask

  task automatic test_stall();
    int e[8];
    logic [7:0] w1, w2;
    for (int i = 0; i < 8; i++) e[i] = int'($urandom_range(0, 3));
    w1 = word4(e[0], e[1], e[2], e[3]);
    w2 = word4(e[4], e[5], e[6], e[7]);
    ra = 1'b0;
    for (int i = 0; i < 7; i++) begin
      va = 1'b1; da = 2'(e[i]);
      #1;
      checks++;
      if (ready_a !== 1'b1) begin
        errors++; $display("FAIL stall_accept%0d: got ready=%b want 1", i, ready_a);
      end
      step();
      if (i >= 3) begin
        checks++;
        if (valid_a !== 1'b1 || packed_a !== w1) begin
          errors++; $display("FAIL stall_hold%0d: got valid=%b packed=%h want 1/%h", i, valid_a, packed_a, w1);
        end
      end
    end
    da = 2'(e[7]);
    #1;
    checks++;
    if (ready_a !== 1'b0) begin
      errors++; $display("FAIL stall_block: got ready=%b want 0", ready_a);
    end
    step();
    checks++;
    if (valid_a !== 1'b1 || packed_a !== w1) begin
      errors++; $display("FAIL stall_still: got valid=%b packed=%h want 1/%h", valid_a, packed_a, w1);
    end
    ra = 1'b1;
    #1;
    checks++;
    if (ready_a !== 1'b1) begin
      errors++; $display("FAIL stall_release: got ready=%b want 1", ready_a);
    end
    step();
    va = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || packed_a !== w2) begin
      errors++; $display("FAIL stall_nobubble: got valid=%b packed=%h want 1/%h", valid_a, packed_a, w2);
    end
    step();
    checks++;
    if (valid_a !== 1'b0) begin
      errors++; $display("FAIL stall_drain: got valid=%b want 0", valid_a);
    end
  endtask

  task automatic test_async_reset();
    ra = 1'b1;
    for (int i = 0; i < 2; i++) begin va = 1'b1; da = 2'(3 - i); step(); end
    va = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid_a !== 1'b0 || packed_a !== 8'h00) begin
      errors++; $display("FAIL areset_mid: got valid=%b packed=%h want 0/00", valid_a, packed_a);
    end
    #1 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      va = 1'b1; da = 2'(i);
      #1;
      checks++;
      if (valid_a !== 1'b0) begin
        errors++; $display("FAIL areset_clean%0d: got valid=%b want 0", i, valid_a);
      end
      step();
    end
    va = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || packed_a !== word4(0, 1, 2, 3)) begin
      errors++; $display("FAIL areset_word: got valid=%b packed=%h want 1/%h", valid_a, packed_a, word4(0, 1, 2, 3));
    end
    ra = 1'b0;
    for (int i = 0; i < 4; i++) begin va = 1'b1; da = 2'(3); step(); end
    va = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid_a !== 1'b0 || packed_a !== 8'h00 || ready_a !== 1'b1) begin
      errors++; $display("FAIL areset_stall: got valid=%b packed=%h ready=%b want 0/00/1", valid_a, packed_a, ready_a);
    end
    #1 rst_n = 1'b1;
    ra = 1'b1;
    step();
  endtask

`ifdef PACKER_FLUSH_EN
  task automatic test_flush();
    ra = 1'b1;
    va = 1'b1; da = 2'd3; step();
    da = 2'd1; step();
    va = 1'b0; fl_a = 1'b1;
    step();
    fl_a = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || packed_a !== 8'h07 || cnt_a !== 3'd2) begin
      errors++; $display("FAIL flush_word: got valid=%b packed=%h count=%0d want 1/07/2", valid_a, packed_a, cnt_a);
    end
    step();
    fl_a = 1'b1;
    step();
    checks++;
    if (valid_a !== 1'b0) begin
      errors++; $display("FAIL flush_empty: got valid=%b want 0", valid_a);
    end
    step();
    fl_a = 1'b0;
    checks++;
    if (valid_a !== 1'b0) begin
      errors++; $display("FAIL flush_empty2: got valid=%b want 0", valid_a);
    end
  endtask
`endif

  // Scoreboard: accepted elements queue up; each output word is re-split LSB-first and matched.
  task automatic test_random(input int sel, input int cycles);
    int w, n, part, mask;
    int inq[$];
    bit mvalid, v, r, exp_ready, in_fire, out_fire;
    int d, lane, want;
    logic [31:0] obs_packed;
    logic obs_valid, obs_ready;
    w = sel ? 3 : 2;
    n = sel ? 3 : 4;
    mask = (1 << w) - 1;
    part = 0; mvalid = 0;
    pulse_reset();
    for (int c = 0; c < cycles; c++) begin
      obs_valid = sel ? valid_b : valid_a;
      checks++;
      if (obs_valid !== mvalid) begin
        errors++; $display("FAIL rnd%0d_valid c%0d: got %b want %b", sel, c, obs_valid, mvalid);
      end
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = int'($urandom_range(0, mask));
      if (sel != 0) begin vb = v; rb = r; db = 3'(d); end
      else begin va = v; ra = r; da = 2'(d); end
      #1;
      obs_ready  = sel ? ready_b : ready_a;
      obs_packed = sel ? 32'(packed_b) : 32'(packed_a);
      exp_ready  = !((part == n - 1) && mvalid && !r);
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL rnd%0d_ready c%0d: got %b want %b", sel, c, obs_ready, exp_ready);
      end
      in_fire  = v && exp_ready;
      out_fire = mvalid && r;
      if (out_fire) begin
        for (int k = 0; k < n; k++) begin
          lane = int'((obs_packed >> (k * w)) & 32'(mask));
          want = (inq.size() > 0) ? inq.pop_front() : -1;
          checks++;
          if (lane !== want) begin
            errors++; $display("FAIL rnd%0d_lane c%0d k%0d: got %0d want %0d", sel, c, k, lane, want);
          end
        end
        mvalid = 0;
      end
      if (in_fire) begin
        inq.push_back(d);
        part++;
        if (part == n) begin part = 0; mvalid = 1; end
      end
      step();
    end
    va = 1'b0; vb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_async_reset();
`ifdef PACKER_FLUSH_EN
    test_flush();
`endif
    test_random(0, 600);
    test_random(1, 600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
